sreg_load_ctrl: RTL and testbench
=================================

Name: sreg_load_ctrl

Overview:
- Sequencer for the 8-bit serial shift chain. Accepts a parallel configuration word over a valid/ready handshake and shifts it MSB-first into the chain through `sin`, gated by a per-bit shift enable.
- Captures the chain's previous contents from its last stage (`sout`), then pulses `update` so downstream logic latches the new parallel value.
- Returns the old contents over a response handshake.
- Sits between the configuration bus and the shift-chain instance; the clock-phase generator gates the chain clocks with `shift_en`.

Parameters:
- N, 8, chain length in bits (≥ 2).
- DIV, 1, cycles per bit slot (≥ 1). `shift_en` fires once per slot.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request word valid
- req_ready  out  1  controller can accept a request
- req_data  in  N  word to load into the chain
- sin  out  1  serial data into chain stage 0
- shift_en  out  1  one-cycle chain shift strobe
- sout  in  1  chain last stage (`q[N-1]`)
- update  out  1  one-cycle pulse: chain holds the new word
- busy  out  1  high whenever state ≠ IDLE
- rsp_valid  out  1  previous-contents word valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  N  chain contents prior to this load

Behaviour:
- One clock `clk`; synchronous active-high `reset`. All state updates on the rising edge of `clk`.
- Reset values: state=IDLE, req_ready=1, sin=0, shift_en=0, update=0, busy=0, rsp_valid=0, rsp_data=0. Bit and slot counters are cleared.
- Reset mid-operation aborts immediately. The chain is left partially shifted, no `update` is issued, and no response is produced.
- States: IDLE, SHIFT, UPDATE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_data into shift register `sr`, clear counters, go to SHIFT.
- SHIFT (N slots of DIV cycles each):
  - `sin` = sr[N-1], held stable for the whole slot.
  - `shift_en`=1 only on the last cycle of each slot.
  - On that cycle: sample `sout` into the LSB of capture register `cap` (cap shifts left), and shift `sr` left.
  - Bit k (k=0..N-1) drives req_data[N-1-k] and captures old q[N-1-k].
  - After the Nth strobe, go to UPDATE. With DIV=1, `shift_en` is high for N consecutive cycles.
- UPDATE:
  - `update`=1 for exactly one cycle, `shift_en`=0.
  - rsp_data<=cap, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data held stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE. req_ready rises the next cycle (no same-cycle bypass).
- Back-pressure: req_ready=0 outside IDLE. Requests presented while busy are not accepted and are not lost; the requester holds them.
- Latency with DIV=1: accept at cycle 0 → shift_en cycles 1..N → update at N+1 → rsp_valid from N+2.
- In general: update at N·DIV+1, rsp_valid at N·DIV+2.
- shift_en and update are never high in the same cycle. Exactly N shift_en pulses occur per transaction.
- Counters:
  - Bit counter width $clog2(N+1).
  - Slot counter width $clog2(DIV) (min 1). It wraps at DIV-1.

Decomposition:
- Shared package `sreg_ctrl_pkg` holds:
  - state enum (IDLE, SHIFT, UPDATE, RESP), 2-bit encoded;
  - localparam default chain length 8;
  - slot-counter width function.
- One natural sub-module, `sreg_slot_cnt`:
  - parameterised DIV/N bit-and-slot counter;
  - outputs `slot_last` and `bit_last`;
  - synchronous clear input.

Test Plan:
1. Load with N=8, DIV=1: chain model preloaded 0x3C; req_data=0xA5 accepted at cycle 0. Expect:
   - sin over strobes = 1,0,1,0,0,1,0,1;
   - shift_en high for cycles 1–8;
   - update at cycle 9;
   - model q=0xA5;
   - rsp_valid at cycle 10 with rsp_data=0x3C.
2. DIV=3, req_data=0x81: shift_en on cycles 3,6,…,24 only; sin stable within each 3-cycle slot; update at cycle 25; final q=0x81.
3. Back-pressure: rsp_ready held low 5 cycles → rsp_valid/rsp_data stable, req_ready=0. A second req_valid in that window is not accepted; it is accepted the cycle after rsp handshake + 1.
4. Back-to-back loads 0xFF then 0x00: second response returns 0xFF; chain ends at 0x00; exactly 16 shift_en pulses total.
5. Reset asserted after 4 shift strobes: next cycle shift_en=0, update never pulses, rsp_valid=0, req_ready=1. A fresh load of 0x5A completes correctly.
6. Boundary N=2, DIV=1: req_data=2'b10 → sin = 1 then 0; update at cycle 3; rsp_valid at cycle 4.

Source files
------------

// File: rtl/sreg_ctrl_pkg.sv
// Shared types and helpers for the serial shift-chain load controller.
package sreg_ctrl_pkg;

  // Controller phases: accept, serialise, latch, return old contents.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StUpdate = 2'd2,
    StResp   = 2'd3
  } state_e;

  localparam int unsigned DefaultN = 8;

  // Width of the slot counter; a single-cycle slot still needs one bit.
  function automatic int unsigned slot_cnt_w(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sreg_slot_cnt.sv
// Bit/slot counter: DIV cycles per slot, N slots per load.
module sreg_slot_cnt
  import sreg_ctrl_pkg::*;
#(
  parameter int unsigned N   = DefaultN,
  parameter int unsigned DIV = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic slot_last_o,
  output logic bit_last_o
);

  localparam int unsigned SlotW = slot_cnt_w(DIV);
  localparam int unsigned BitW  = $clog2(N + 1);
  localparam logic [SlotW-1:0] SlotMax = SlotW'(DIV - 1);
  localparam logic [BitW-1:0]  BitMax  = BitW'(N - 1);

  logic [SlotW-1:0] slot_q, slot_d;
  logic [BitW-1:0]  bit_q, bit_d;

  assign slot_last_o = (slot_q == SlotMax);
  assign bit_last_o  = (bit_q == BitMax);

  // Slot counter wraps each slot; bit counter advances on the slot's last cycle.
  always_comb begin
    slot_d = slot_q;
    bit_d  = bit_q;
    if (clr_i) begin
      slot_d = '0;
      bit_d  = '0;
    end else if (en_i) begin
      if (slot_last_o) begin
        slot_d = '0;
        bit_d  = bit_q + 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_q <= '0;
      bit_q  <= '0;
    end else begin
      slot_q <= slot_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/sreg_load_ctrl.sv
// Loads a parallel word MSB-first into a serial chain, captures the old
// contents from the chain tail, pulses update and returns the old word.
module sreg_load_ctrl
  import sreg_ctrl_pkg::*;
#(
  parameter int unsigned N   = DefaultN,
  parameter int unsigned DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_data,
  output logic         sin,
  output logic         shift_en,
  input  logic         sout,
  output logic         update,
  output logic         busy,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data
);

  state_e       state_q, state_d;
  logic [N-1:0] sr_q, sr_d;
  logic [N-1:0] cap_q, cap_d;
  logic [N-1:0] rsp_q, rsp_d;
  logic         slot_last;
  logic         bit_last;

  // Counters run only while shifting and are held clear otherwise.
  sreg_slot_cnt #(
    .N  (N),
    .DIV(DIV)
  ) u_slot_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .clr_i      (state_q != StShift),
    .en_i       (state_q == StShift),
    .slot_last_o(slot_last),
    .bit_last_o (bit_last)
  );

  assign busy     = (state_q != StIdle);
  assign rsp_data = rsp_q;

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cap_d     = cap_q;
    rsp_d     = rsp_q;
    req_ready = 1'b0;
    sin       = 1'b0;
    shift_en  = 1'b0;
    update    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          sr_d    = req_data;
          cap_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // sin follows the MSB, so it is stable across the whole slot.
        sin = sr_q[N-1];
        if (slot_last) begin
          shift_en = 1'b1;
          cap_d    = {cap_q[N-2:0], sout};
          sr_d     = {sr_q[N-2:0], 1'b0};
          if (bit_last) state_d = StUpdate;
        end
      end
      StUpdate: begin
        update  = 1'b1;
        rsp_d   = cap_q;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
    end
  end

endmodule

// File: tb/tb_sreg_load_ctrl.sv
// Bench for sreg_load_ctrl: three instances (N=8/DIV=1, N=8/DIV=3, N=2/DIV=1)
// each driving a behavioural shift chain.
module tb_sreg_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Instance A: N=8, DIV=1
  logic       a_req_valid, a_req_ready, a_sin, a_shift_en, a_sout, a_update;
  logic       a_busy, a_rsp_valid, a_rsp_ready;
  logic [7:0] a_req_data, a_rsp_data;
  // Instance B: N=8, DIV=3
  logic       b_req_valid, b_req_ready, b_sin, b_shift_en, b_sout, b_update;
  logic       b_busy, b_rsp_valid, b_rsp_ready;
  logic [7:0] b_req_data, b_rsp_data;
  // Instance C: N=2, DIV=1
  logic       c_req_valid, c_req_ready, c_sin, c_shift_en, c_sout, c_update;
  logic       c_busy, c_rsp_valid, c_rsp_ready;
  logic [1:0] c_req_data, c_rsp_data;

  sreg_load_ctrl #(.N(8), .DIV(1)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_data(a_req_data), .sin(a_sin), .shift_en(a_shift_en), .sout(a_sout),
    .update(a_update), .busy(a_busy), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_data(a_rsp_data)
  );

  sreg_load_ctrl #(.N(8), .DIV(3)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_data(b_req_data), .sin(b_sin), .shift_en(b_shift_en), .sout(b_sout),
    .update(b_update), .busy(b_busy), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_data(b_rsp_data)
  );

  sreg_load_ctrl #(.N(2), .DIV(1)) u_dut_c (
    .clk(clk), .reset(reset), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_data(c_req_data), .sin(c_sin), .shift_en(c_shift_en), .sout(c_sout),
    .update(c_update), .busy(c_busy), .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready),
    .rsp_data(c_rsp_data)
  );

  // Behavioural shift chains (the environment), with a preload hook.
  logic       pre_en;
  logic [7:0] pre_a, pre_b;
  logic [1:0] pre_c;
  logic [7:0] qa, qb;
  logic [1:0] qc;
  int         a_se_cnt  = 0;
  int         a_upd_cnt = 0;
  int         b_se_cnt  = 0;

  assign a_sout = qa[7];
  assign b_sout = qb[7];
  assign c_sout = qc[1];

  always @(posedge clk) begin
    if (pre_en) begin
      qa <= pre_a;
      qb <= pre_b;
      qc <= pre_c;
    end else begin
      if (a_shift_en) qa <= {qa[6:0], a_sin};
      if (b_shift_en) qb <= {qb[6:0], b_sin};
      if (c_shift_en) qc <= {qc[0], c_sin};
    end
    if (a_shift_en) a_se_cnt <= a_se_cnt + 1;
    if (a_update) a_upd_cnt <= a_upd_cnt + 1;
    if (b_shift_en) b_se_cnt <= b_se_cnt + 1;
  end

  // Expected chain-A contents: the last fully loaded (or partially shifted) word.
  logic [7:0] mdl_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full load on instance A starting in an idle cycle (cycle 0).
  // rdly: cycles rsp_ready is held low; pend: present another request meanwhile.
  task automatic txn_a(input logic [7:0] d, input int rdly, input logic pend,
                       input logic [7:0] pd);
    logic [7:0] exp_old;
    int         se0;
    exp_old = mdl_a;
    se0     = a_se_cnt;
    chk1("a_idle_ready", a_req_ready, 1'b1);
    a_req_valid = 1'b1;
    a_req_data  = d;
    for (int k = 1; k <= 8; k++) begin
      tick();
      a_req_valid = 1'b0;
      chk1("a_shift_en", a_shift_en, 1'b1);
      chk1("a_sin", a_sin, d[8-k]);
      chk1("a_no_update_in_shift", a_update, 1'b0);
      chk1("a_ready_while_busy", a_req_ready, 1'b0);
    end
    tick();
    chk1("a_update", a_update, 1'b1);
    chk1("a_shift_en_in_update", a_shift_en, 1'b0);
    chk1("a_rsp_valid_in_update", a_rsp_valid, 1'b0);
    chk8("a_chain_loaded", qa, d);
    tick();
    for (int w = 0; w < rdly; w++) begin
      if (pend) begin
        a_req_valid = 1'b1;
        a_req_data  = pd;
      end
      chk1("a_rsp_valid_hold", a_rsp_valid, 1'b1);
      chk8("a_rsp_data_hold", a_rsp_data, exp_old);
      chk1("a_ready_in_resp", a_req_ready, 1'b0);
      chk1("a_no_accept_in_resp", a_shift_en, 1'b0);
      tick();
    end
    a_rsp_ready = 1'b1;
    chk1("a_rsp_valid", a_rsp_valid, 1'b1);
    chk8("a_rsp_data", a_rsp_data, exp_old);
    chk1("a_ready_at_handshake", a_req_ready, 1'b0);
    tick();
    a_rsp_ready = 1'b0;
    chk1("a_rsp_valid_dropped", a_rsp_valid, 1'b0);
    chk1("a_ready_after_rsp", a_req_ready, 1'b1);
    chk1("a_busy_after_rsp", a_busy, 1'b0);
    chk_int("a_pulses_per_txn", a_se_cnt - se0, 8);
    mdl_a = d;
  endtask

  initial begin
    logic [7:0] bd;
    logic [1:0] cd;
    int         se0;
    int         upd0;

    reset       = 1'b1;
    pre_en      = 1'b1;
    pre_a       = 8'h3C;
    pre_b       = 8'hC3;
    pre_c       = 2'b01;
    a_req_valid = 1'b0; a_req_data = '0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_data = '0; b_rsp_ready = 1'b0;
    c_req_valid = 1'b0; c_req_data = '0; c_rsp_ready = 1'b0;
    mdl_a       = 8'h3C;
    tick();
    pre_en = 1'b0;
    tick();

    // Reset state
    chk1("rst_req_ready", a_req_ready, 1'b1);
    chk1("rst_sin", a_sin, 1'b0);
    chk1("rst_shift_en", a_shift_en, 1'b0);
    chk1("rst_update", a_update, 1'b0);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_rsp_valid", a_rsp_valid, 1'b0);
    chk8("rst_rsp_data", a_rsp_data, 8'h00);
    chk1("rst_b_busy", b_busy, 1'b0);
    chk1("rst_c_busy", c_busy, 1'b0);
    chk1("rst_c_ready", c_req_ready, 1'b1);
    reset = 1'b0;
    tick();

    // Basic load 0xA5 over preloaded 0x3C
    txn_a(8'hA5, 0, 1'b0, 8'h00);

    // Response back-pressure with a held request that must wait
    txn_a(8'h3C, 5, 1'b1, 8'h96);
    txn_a(8'h96, 0, 1'b0, 8'h00);

    // Back-to-back 0xFF then 0x00
    se0 = a_se_cnt;
    txn_a(8'hFF, 0, 1'b0, 8'h00);
    txn_a(8'h00, 0, 1'b0, 8'h00);
    chk_int("b2b_pulses", a_se_cnt - se0, 16);
    chk8("b2b_chain", qa, 8'h00);

    // Reset after four strobes of 0x77
    chk1("a_ready_pre_abort", a_req_ready, 1'b1);
    a_req_valid = 1'b1;
    a_req_data  = 8'h77;
    for (int k = 1; k <= 4; k++) begin
      tick();
      a_req_valid = 1'b0;
      chk1("abort_shift_en", a_shift_en, 1'b1);
    end
    reset = 1'b1;
    upd0  = a_upd_cnt;
    tick();
    reset = 1'b0;
    chk1("abort_shift_en_off", a_shift_en, 1'b0);
    chk1("abort_rsp_valid", a_rsp_valid, 1'b0);
    chk1("abort_req_ready", a_req_ready, 1'b1);
    chk1("abort_busy", a_busy, 1'b0);
    for (int k = 0; k < 12; k++) tick();
    chk_int("abort_no_update", a_upd_cnt - upd0, 0);
    chk1("abort_rsp_valid_late", a_rsp_valid, 1'b0);
    // Four bits of 0x7_ entered; the chain keeps its low nibble moved up.
    mdl_a = {mdl_a[3:0], 4'h7};
    chk8("abort_chain_partial", qa, mdl_a);
    txn_a(8'h5A, 0, 1'b0, 8'h00);

    // Randomised loads with random response back-pressure
    for (int i = 0; i < 8; i++) begin
      txn_a(8'($urandom), int'($urandom_range(0, 3)), 1'b0, 8'h00);
    end
    chk8("rand_chain_final", qa, mdl_a);

    // Instance B: DIV=3, load 0x81 over 0xC3
    bd = 8'h81;
    chk1("b_idle_ready", b_req_ready, 1'b1);
    b_req_valid = 1'b1;
    b_req_data  = bd;
    for (int c = 1; c <= 24; c++) begin
      tick();
      b_req_valid = 1'b0;
      chk1("b_shift_en", b_shift_en, (c % 3) == 0);
      chk1("b_sin", b_sin, bd[7-(c-1)/3]);
      chk1("b_no_update", b_update, 1'b0);
    end
    tick();
    chk1("b_update", b_update, 1'b1);
    chk1("b_shift_en_in_update", b_shift_en, 1'b0);
    chk8("b_chain_loaded", qb, 8'h81);
    tick();
    chk1("b_rsp_valid", b_rsp_valid, 1'b1);
    chk8("b_rsp_data", b_rsp_data, 8'hC3);
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
    chk1("b_ready_after", b_req_ready, 1'b1);
    chk1("b_rsp_valid_dropped", b_rsp_valid, 1'b0);
    chk_int("b_pulses", b_se_cnt, 8);

    // Instance C: N=2, load 2'b10 over 2'b01
    cd = 2'b10;
    c_req_valid = 1'b1;
    c_req_data  = cd;
    tick();
    c_req_valid = 1'b0;
    chk1("c_se_1", c_shift_en, 1'b1);
    chk1("c_sin_1", c_sin, cd[1]);
    tick();
    chk1("c_se_2", c_shift_en, 1'b1);
    chk1("c_sin_2", c_sin, cd[0]);
    tick();
    chk1("c_update", c_update, 1'b1);
    chk1("c_se_3", c_shift_en, 1'b0);
    chk1("c_rsp_valid_3", c_rsp_valid, 1'b0);
    chk8("c_chain", {6'b0, qc}, 8'h02);
    tick();
    chk1("c_rsp_valid", c_rsp_valid, 1'b1);
    chk8("c_rsp_data", {6'b0, c_rsp_data}, 8'h01);
    c_rsp_ready = 1'b1;
    tick();
    c_rsp_ready = 1'b0;
    chk1("c_ready_after", c_req_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
